// File: rtl/shift_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | shift_scheduler: syncs/debounces shift buttons, arbitrates one gear command   |
// | per dwell period. Optional macro SHIFT_SCHED_AUTO_DOWN_EN. Revision: 1.0      |
// +-----------------------------------------------------------------------------+
module shift_scheduler #(
  parameter int DEB_CYCLES   = 8,
  parameter int DWELL_CYCLES = 250,
  parameter int MAX_GEAR     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up_raw,
  input  logic       down_raw,
  input  logic       brake_raw,
  input  logic [2:0] gear_cur,
  output logic       up_pulse,
  output logic       down_pulse,
  output logic       brake_pulse,
  output logic       reject_pulse,
  output logic       busy
);

  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam int DWW = $clog2(DWELL_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;

  localparam logic [1:0] SEL_UP    = 2'd0;
  localparam logic [1:0] SEL_DOWN  = 2'd1;
  localparam logic [1:0] SEL_BRAKE = 2'd2;

  // Bit order everywhere: [0]=up, [1]=down, [2]=brake
  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] deb;
  logic [2:0] deb_d;
  logic [2:0] rise;
  logic [2:0] pend;
  logic [2:0] req;
  logic [2:0] clr;

  logic [1:0]     state;
  logic [1:0]     state_nxt;
  logic [1:0]     sel;
  logic [1:0]     sel_nxt;
  logic [DWW-1:0] dwell_cnt;
  logic           reject_q;
  logic           rej;
  logic [2:0]     gear_eff;

  assign raw = {brake_raw, down_raw, up_raw};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
      deb_d <= 3'b000;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_deb
      logic [DCW-1:0] cnt;
      logic           lvl;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt <= '0;
          lvl <= 1'b0;
        end else if (sync2[gi] == lvl) begin
          cnt <= '0;
        end else if (cnt == DCW'(DEB_CYCLES - 1)) begin
          lvl <= sync2[gi];
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign deb[gi] = lvl;
    end
  endgenerate

  assign rise     = deb & ~deb_d;
  assign gear_eff = (gear_cur > 3'(MAX_GEAR)) ? 3'(MAX_GEAR) : gear_cur;

`ifdef SHIFT_SCHED_AUTO_DOWN_EN
  // Held brake injects a downshift each time the dwell expires, stopping at gear 1
  logic auto_down;
  assign auto_down = deb[2] && (gear_eff > 3'd1) && (state == S_DWELL) && (dwell_cnt == '0);
  assign req       = pend | {1'b0, auto_down, 1'b0};
`else
  assign req = pend;
`endif

  // Dwell expiry is handled as the return to IDLE, so a waiting request issues without a gap
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    clr       = 3'b000;
    rej       = 1'b0;
    case (state)
      S_IDLE, S_DWELL: begin
        if (req[2]) begin
          state_nxt = S_ISSUE;
          sel_nxt   = SEL_BRAKE;
        end else if ((state == S_IDLE) || (dwell_cnt == '0)) begin
          state_nxt = S_IDLE;
          if (req[1]) begin
            if (gear_eff == 3'd0) begin
              clr[1] = 1'b1;
              rej    = 1'b1;
            end else begin
              state_nxt = S_ISSUE;
              sel_nxt   = SEL_DOWN;
            end
          end else if (req[0]) begin
            if (gear_eff == 3'(MAX_GEAR)) begin
              clr[0] = 1'b1;
              rej    = 1'b1;
            end else begin
              state_nxt = S_ISSUE;
              sel_nxt   = SEL_UP;
            end
          end
        end
      end
      S_ISSUE: begin
        state_nxt = S_DWELL;
        clr       = 3'(3'b001 << sel);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sel       <= SEL_UP;
      dwell_cnt <= '0;
      reject_q  <= 1'b0;
      pend      <= 3'b000;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      reject_q <= rej;
      pend     <= (pend | rise) & ~clr;
      if (state == S_ISSUE) begin
        dwell_cnt <= DWW'(DWELL_CYCLES - 1);
      end else if ((state == S_DWELL) && (dwell_cnt != '0)) begin
        dwell_cnt <= dwell_cnt - 1'b1;
      end
    end
  end

  assign up_pulse     = (state == S_ISSUE) && (sel == SEL_UP);
  assign down_pulse   = (state == S_ISSUE) && (sel == SEL_DOWN);
  assign brake_pulse  = (state == S_ISSUE) && (sel == SEL_BRAKE);
  assign reject_pulse = reject_q;
  assign busy         = (state == S_ISSUE) || (state == S_DWELL);

endmodule
`default_nettype wire
